// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_pkg : shared types and encodings for the load/store unit          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  function automatic logic func3_illegal(input logic is_store, input logic [2:0] func3);
    if (is_store) begin
      return !(func3 == SB || func3 == SH || func3 == SW);
    end
    return (func3 == 3'b011) || (func3 == 3'b110) || (func3 == 3'b111);
  endfunction

  // Halfword alignment applies to both signed and unsigned halfword loads.
  function automatic logic func3_misaligned(input logic [2:0] func3, input logic [1:0] offset);
    if (func3 == LH || func3 == LHU) begin
      return offset[0];
    end
    if (func3 == LW) begin
      return offset != 2'b00;
    end
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_if : request, response and data-memory signals of the LSU         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_store, req_func3, req_addr, req_wdata, req_rd,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_rd, resp_err,
    output mem_addr, mem_wdata, mem_func3, mem_rw
  );

  modport master (
    output req_valid, req_is_store, req_func3, req_addr, req_wdata, req_rd,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_err,
    input  mem_addr, mem_wdata, mem_func3, mem_rw
  );

endinterface
`default_nettype wire

// File: rtl/lsu_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_check : classifies a request as ok/misaligned/out-of-range/illegal|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module lsu_check
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 11
) (
  input  wire logic        i_is_store,
  input  wire logic [2:0]  i_func3,
  input  wire logic [31:0] i_addr,
  output logic      [1:0]  o_err
);

  logic w_illegal;
  logic w_misaligned;
  logic w_out_of_range;

  always_comb begin
    w_illegal      = func3_illegal(i_is_store, i_func3);
    w_misaligned   = func3_misaligned(i_func3, i_addr[1:0]);
    w_out_of_range = ({2'b00, i_addr[31:2]} >= 32'(MEM_WORDS));

    // Illegal encoding dominates, then alignment, then range.
    if (w_illegal) begin
      o_err = ERR_ILLEGAL;
    end else if (w_misaligned) begin
      o_err = ERR_MISALIGN;
    end else if (w_out_of_range) begin
      o_err = ERR_RANGE;
    end else begin
      o_err = ERR_OK;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu : single-outstanding load/store unit, IDLE -> ACCESS -> RESP      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 11
) (
  input  wire logic clk,
  input  wire logic rst,
  lsu_if.slave      bus
);

  state_t      r_state;
  state_t      w_state_next;

  logic        r_is_store;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_resp_data;
  logic [4:0]  r_resp_rd;
  logic [1:0]  r_resp_err;

  logic [1:0]  w_err;
  logic        w_accept;
  logic        w_load_capture;
  logic        w_req_ready;
  logic        w_resp_valid;
  logic        w_mem_rw;

  lsu_check #(
    .MEM_WORDS (MEM_WORDS)
  ) u_check (
    .i_is_store (bus.req_is_store),
    .i_func3    (bus.req_func3),
    .i_addr     (bus.req_addr),
    .o_err      (w_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_accept       = 1'b0;
    w_load_capture = 1'b0;
    w_req_ready    = 1'b0;
    w_resp_valid   = 1'b0;
    w_mem_rw       = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept     = 1'b1;
          // Faulty requests skip the memory entirely.
          w_state_next = (w_err == ERR_OK) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        w_mem_rw       = r_is_store;
        w_load_capture = !r_is_store;
        w_state_next   = RESP;
      end
      RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_store  <= 1'b0;
      r_func3     <= 3'b000;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_resp_data <= 32'd0;
      r_resp_rd   <= 5'd0;
      r_resp_err  <= ERR_OK;
    end else begin
      if (w_accept) begin
        r_is_store  <= bus.req_is_store;
        r_func3     <= bus.req_func3;
        r_addr      <= bus.req_addr;
        r_wdata     <= bus.req_wdata;
        r_resp_data <= 32'd0;
        r_resp_rd   <= bus.req_is_store ? 5'd0 : bus.req_rd;
        r_resp_err  <= w_err;
      end
      if (w_load_capture) begin
        r_resp_data <= bus.mem_rdata;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_rd    = r_resp_rd;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_func3  = r_func3;
  assign bus.mem_rw     = w_mem_rw;

endmodule
`default_nettype wire
